// File: rtl/riscv_scoreboard_if.sv
// Decode/writeback hazard-tracking bundle between the pipeline and the scoreboard.
// Purely wiring; no latency. Stall is the only backpressure and flows back as stall_D.
interface riscv_scoreboard_if;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       use_rs1_D;
  logic       use_rs2_D;
  logic       issue_vld_D;
  logic [4:0] issue_rd_D;
  logic       issue_long_D;
  logic       wb_vld_W;
  logic [4:0] wb_rd_W;
  logic       flush;
  logic       stall_D;
  logic [5:0] pending_cnt;
  logic       err_uflow;

  modport master (
    output rs1_D, rs2_D, use_rs1_D, use_rs2_D,
    output issue_vld_D, issue_rd_D, issue_long_D,
    output wb_vld_W, wb_rd_W, flush,
    input  stall_D, pending_cnt, err_uflow
  );

  modport slave (
    input  rs1_D, rs2_D, use_rs1_D, use_rs2_D,
    input  issue_vld_D, issue_rd_D, issue_long_D,
    input  wb_vld_W, wb_rd_W, flush,
    output stall_D, pending_cnt, err_uflow
  );
endinterface

// File: rtl/riscv_scoreboard.sv
// Counts outstanding long-latency (load/MUL/DIV) writes per register and stalls decode on RAW/WAW hazards.
// stall_D is combinational; counters update on the next edge, pending_cnt is registered alongside them.
// Backpressure: stall_D holds D and blocks issue; a full counter blocks further long issues to that rd.
module riscv_scoreboard #(
  parameter int NREGS     = 32,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input logic               clk,
  input logic               rst,
  riscv_scoreboard_if.slave sb
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  cnt_t       cnt_q [1:NREGS-1];
  cnt_t       cnt_d [1:NREGS-1];
  logic [5:0] pend_q, pend_d;
  logic       err_q, err_d;

  logic       hit1, hit2, raw, waw, stall, acc;

  // x0 and out-of-range registers read as an empty counter.
  function automatic cnt_t cnt_of(input logic [4:0] r);
    cnt_t c;
    c = '0;
    if (r != 5'd0 && int'(r) < NREGS) c = cnt_q[int'(r)];
    return c;
  endfunction

  always_comb begin
    hit1  = (cnt_of(sb.rs1_D) != '0) &&
            !(WB_BYPASS && sb.wb_vld_W && sb.wb_rd_W == sb.rs1_D && cnt_of(sb.rs1_D) == CNT_ONE);
    hit2  = (cnt_of(sb.rs2_D) != '0) &&
            !(WB_BYPASS && sb.wb_vld_W && sb.wb_rd_W == sb.rs2_D && cnt_of(sb.rs2_D) == CNT_ONE);
    raw   = (sb.use_rs1_D && hit1) || (sb.use_rs2_D && hit2);
    waw   = sb.issue_vld_D && sb.issue_long_D && sb.issue_rd_D != 5'd0 &&
            cnt_of(sb.issue_rd_D) == CNT_MAX;
    stall = !rst && !sb.flush && (raw || waw);
    acc   = sb.issue_vld_D && sb.issue_long_D && !stall && !sb.flush && sb.issue_rd_D != 5'd0;
  end

  always_comb begin
    logic inc;
    logic dec;
    inc    = 1'b0;
    dec    = 1'b0;
    pend_d = '0;
    err_d  = err_q;
    if (sb.wb_vld_W && sb.wb_rd_W != 5'd0 && cnt_of(sb.wb_rd_W) == '0) err_d = 1'b1;
    for (int r = 1; r < NREGS; r++) begin
      inc = acc && int'(sb.issue_rd_D) == r;
      dec = sb.wb_vld_W && int'(sb.wb_rd_W) == r && cnt_q[r] != '0;
      // Flush discards everything in flight, including this cycle's issue/writeback.
      if (sb.flush)         cnt_d[r] = '0;
      else if (inc && !dec) cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_ONE;
      else                  cnt_d[r] = cnt_q[r];
      pend_d = pend_d + 6'(cnt_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) cnt_q[r] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall_D     = stall;
  assign sb.pending_cnt = pend_q;
  assign sb.err_uflow   = err_q;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Bench for riscv_scoreboard: two instances (writeback bypass on/off) fed identical stimulus,
// checked against a per-register count model in directed scenarios and a randomized run.
module tb_riscv_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1, rs2, ird, wrd;
  logic       u1, u2, iv, il, wv, fl;
  int         runs  = 0;
  int         fails = 0;

  int mc [2][32];
  bit merr [2];
  int mpend [2];

  riscv_scoreboard_if if0 ();
  riscv_scoreboard_if if1 ();

  assign if0.rs1_D = rs1;        assign if1.rs1_D = rs1;
  assign if0.rs2_D = rs2;        assign if1.rs2_D = rs2;
  assign if0.use_rs1_D = u1;     assign if1.use_rs1_D = u1;
  assign if0.use_rs2_D = u2;     assign if1.use_rs2_D = u2;
  assign if0.issue_vld_D = iv;   assign if1.issue_vld_D = iv;
  assign if0.issue_rd_D = ird;   assign if1.issue_rd_D = ird;
  assign if0.issue_long_D = il;  assign if1.issue_long_D = il;
  assign if0.wb_vld_W = wv;      assign if1.wb_vld_W = wv;
  assign if0.wb_rd_W = wrd;      assign if1.wb_rd_W = wrd;
  assign if0.flush = fl;         assign if1.flush = fl;

  riscv_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1'b1)) u_dut0 (.clk(clk), .rst(rst), .sb(if0));
  riscv_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1'b0)) u_dut1 (.clk(clk), .rst(rst), .sb(if1));

  always #5 clk = ~clk;

  // Model: instance 0 has writeback bypass, instance 1 does not; counters saturate at 3.
  function automatic bit m_hit(int k, int r);
    if (r == 0 || mc[k][r] == 0) return 1'b0;
    if (k == 0 && wv && int'(wrd) == r && mc[k][r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall(int k);
    bit raw, waw;
    raw = (u1 && m_hit(k, int'(rs1))) || (u2 && m_hit(k, int'(rs2)));
    waw = iv && il && ird != 0 && mc[k][ird] == 3;
    return !fl && (raw || waw);
  endfunction

  task automatic m_update(int k);
    bit acc, dec;
    int s;
    acc = iv && il && ird != 0 && !fl && !m_stall(k);
    dec = wv && wrd != 0 && mc[k][wrd] != 0;
    if (wv && wrd != 0 && mc[k][wrd] == 0) merr[k] = 1'b1;
    if (fl) begin
      for (int r = 0; r < 32; r++) mc[k][r] = 0;
    end else begin
      if (acc) mc[k][ird] = mc[k][ird] + 1;
      if (dec) mc[k][wrd] = mc[k][wrd] - 1;
    end
    s = 0;
    for (int r = 0; r < 32; r++) s += mc[k][r];
    mpend[k] = s % 64;
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) mc[k][r] = 0;
      merr[k]  = 1'b0;
      mpend[k] = 0;
    end
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; iv = 0; ird = '0; il = 0; wv = 0; wrd = '0; fl = 0;
  endtask

  task automatic issue(int rd);
    iv = 1'b1; il = 1'b1; ird = 5'(rd);
  endtask

  task automatic wb(int rd);
    wv = 1'b1; wrd = 5'(rd);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    m_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Advance one clock; inputs are applied by the caller before this.
  task automatic step();
    m_update(0);
    m_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", if0.stall_D); end
    runs++;
    if (if0.pending_cnt !== 6'd0) begin fails++; $display("FAIL reset_pending: got %0d want 0", if0.pending_cnt); end
    runs++;
    if (if0.err_uflow !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", if0.err_uflow); end
    runs++;
    idle(); issue(5); step();
    idle(); issue(6); step();
    idle(); wb(4); step();
    idle(); u1 = 1'b1; rs1 = 5'd5;
    #1;
    if (if0.stall_D !== 1'b1) begin fails++; $display("FAIL prereset_stall: got %b want 1", if0.stall_D); end
    runs++;
    if (if0.pending_cnt !== 6'd2) begin fails++; $display("FAIL prereset_pending: got %0d want 2", if0.pending_cnt); end
    runs++;
    #2 rst = 1'b1;
    #1;
    if (if0.stall_D !== 1'b0 || if1.stall_D !== 1'b0) begin
      fails++; $display("FAIL midreset_stall: got %b/%b want 0/0", if0.stall_D, if1.stall_D);
    end
    runs++;
    if (if0.pending_cnt !== 6'd0) begin fails++; $display("FAIL midreset_pending: got %0d want 0", if0.pending_cnt); end
    runs++;
    if (if0.err_uflow !== 1'b0) begin fails++; $display("FAIL midreset_err: got %b want 0", if0.err_uflow); end
    runs++;
    m_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL postreset_stall: got %b want 0", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd0) begin fails++; $display("FAIL postreset_pending: got %0d want 0", if0.pending_cnt); end
    runs++;
  endtask

  task automatic test_load_use();
    do_reset();
    idle(); issue(5);
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL lu_issue_stall: got %b want 0", if0.stall_D); end
    runs++;
    step();
    idle(); u1 = 1'b1; rs1 = 5'd5;
    #1;
    if (if0.stall_D !== 1'b1 || if1.stall_D !== 1'b1) begin
      fails++; $display("FAIL lu_use_stall: got %b/%b want 1/1", if0.stall_D, if1.stall_D);
    end
    runs++;
    step();
    wb(5);
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL lu_wb_bypass: got %b want 0", if0.stall_D); end
    runs++;
    if (if1.stall_D !== 1'b1) begin fails++; $display("FAIL lu_wb_nobypass: got %b want 1", if1.stall_D); end
    runs++;
    step();
    wv = 1'b0;
    #1;
    if (if1.stall_D !== 1'b0 || if0.stall_D !== 1'b0) begin
      fails++; $display("FAIL lu_after_wb: got %b/%b want 0/0", if0.stall_D, if1.stall_D);
    end
    runs++;
    if (if0.pending_cnt !== 6'd0 || if1.pending_cnt !== 6'd0) begin
      fails++; $display("FAIL lu_pending: got %0d/%0d want 0/0", if0.pending_cnt, if1.pending_cnt);
    end
    runs++;
  endtask

  task automatic test_waw();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); issue(7);
      #1;
      if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL waw_issue%0d_stall: got %b want 0", i, if0.stall_D); end
      runs++;
      step();
      if (if0.pending_cnt !== 6'(i + 1)) begin
        fails++; $display("FAIL waw_issue%0d_pending: got %0d want %0d", i, if0.pending_cnt, i + 1);
      end
      runs++;
    end
    idle(); issue(7);
    #1;
    if (if0.stall_D !== 1'b1) begin fails++; $display("FAIL waw_full_stall: got %b want 1", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd3) begin fails++; $display("FAIL waw_full_pending: got %0d want 3", if0.pending_cnt); end
    runs++;
    wb(7);
    #1;
    if (if0.stall_D !== 1'b1) begin fails++; $display("FAIL waw_wb_stall: got %b want 1", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd2) begin fails++; $display("FAIL waw_wb_pending: got %0d want 2", if0.pending_cnt); end
    runs++;
    wv = 1'b0;
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL waw_reissue_stall: got %b want 0", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd3) begin fails++; $display("FAIL waw_reissue_pending: got %0d want 3", if0.pending_cnt); end
    runs++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle(); issue(9); step();
    issue(9); wb(9);
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL b2b_stall: got %b want 0", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd1 || if1.pending_cnt !== 6'd1) begin
      fails++; $display("FAIL b2b_pending: got %0d/%0d want 1/1", if0.pending_cnt, if1.pending_cnt);
    end
    runs++;
    idle(); wb(9); step();
    if (if0.pending_cnt !== 6'd0 || if0.err_uflow !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got pend %0d err %b want 0/0", if0.pending_cnt, if0.err_uflow);
    end
    runs++;
  endtask

  task automatic test_flush();
    do_reset();
    idle(); issue(3); step();
    issue(3); step();
    idle(); issue(12); step();
    if (if0.pending_cnt !== 6'd3) begin fails++; $display("FAIL flush_pre_pending: got %0d want 3", if0.pending_cnt); end
    runs++;
    idle(); fl = 1'b1; issue(20); u1 = 1'b1; rs1 = 5'd3; u2 = 1'b1; rs2 = 5'd12;
    #1;
    if (if0.stall_D !== 1'b0 || if1.stall_D !== 1'b0) begin
      fails++; $display("FAIL flush_stall: got %b/%b want 0/0", if0.stall_D, if1.stall_D);
    end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd0 || if1.pending_cnt !== 6'd0) begin
      fails++; $display("FAIL flush_pending: got %0d/%0d want 0/0", if0.pending_cnt, if1.pending_cnt);
    end
    runs++;
    fl = 1'b0; iv = 1'b0;
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL flush_after_stall: got %b want 0", if0.stall_D); end
    runs++;
  endtask

  task automatic test_uflow();
    do_reset();
    idle(); wb(0); step();
    if (if0.err_uflow !== 1'b0) begin fails++; $display("FAIL uflow_x0_wb: got %b want 0", if0.err_uflow); end
    runs++;
    idle(); issue(0); u1 = 1'b1; rs1 = 5'd0;
    #1;
    if (if0.stall_D !== 1'b0) begin fails++; $display("FAIL uflow_x0_stall: got %b want 0", if0.stall_D); end
    runs++;
    step();
    if (if0.pending_cnt !== 6'd0) begin fails++; $display("FAIL uflow_x0_issue: got %0d want 0", if0.pending_cnt); end
    runs++;
    idle(); wb(4); step();
    if (if0.err_uflow !== 1'b1 || if0.pending_cnt !== 6'd0) begin
      fails++; $display("FAIL uflow_set: got err %b pend %0d want 1/0", if0.err_uflow, if0.pending_cnt);
    end
    runs++;
    idle(); fl = 1'b1; step();
    idle(); step();
    if (if0.err_uflow !== 1'b1) begin fails++; $display("FAIL uflow_sticky: got %b want 1", if0.err_uflow); end
    runs++;
  endtask

  task automatic test_random();
    bit exp_s;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      u1  = ($urandom_range(0, 1) == 1);
      u2  = ($urandom_range(0, 1) == 1);
      iv  = ($urandom_range(0, 1) == 1);
      il  = ($urandom_range(0, 9) < 7);
      ird = 5'($urandom_range(0, 7));
      wrd = 5'($urandom_range(0, 7));
      wv  = ($urandom_range(0, 99) < 40) && (mc[0][wrd] != 0 || $urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      #1;
      exp_s = m_stall(0);
      if (if0.stall_D !== exp_s) begin fails++; $display("FAIL rnd%0d_stall_bp1: got %b want %b", n, if0.stall_D, exp_s); end
      runs++;
      exp_s = m_stall(1);
      if (if1.stall_D !== exp_s) begin fails++; $display("FAIL rnd%0d_stall_bp0: got %b want %b", n, if1.stall_D, exp_s); end
      runs++;
      step();
      if (if0.pending_cnt !== 6'(mpend[0])) begin
        fails++; $display("FAIL rnd%0d_pend_bp1: got %0d want %0d", n, if0.pending_cnt, mpend[0]);
      end
      runs++;
      if (if1.pending_cnt !== 6'(mpend[1])) begin
        fails++; $display("FAIL rnd%0d_pend_bp0: got %0d want %0d", n, if1.pending_cnt, mpend[1]);
      end
      runs++;
      if (if0.err_uflow !== merr[0] || if1.err_uflow !== merr[1]) begin
        fails++; $display("FAIL rnd%0d_err: got %b/%b want %b/%b", n, if0.err_uflow, if1.err_uflow, merr[0], merr[1]);
      end
      runs++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_waw();
    test_back_to_back();
    test_flush();
    test_uflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
